rob_commit: RTL and testbench

- Reorder buffer for the Tomasulo RISC-V core.
- Allocates in-order tags at issue and accepts out-of-order results from the reservation station and the store/load buffer.
- Retires one entry per cycle in program order to the register file and SLB.
- Broadcasts committed values back to waiting RS entries; raises the pipeline-wide clear on a JALR target mispredict.

---
 rtl/rob_commit_pkg.sv | 22 ++
 rtl/rob_tag_lookup.sv | 48 ++++
 rtl/rob_commit.sv | 179 +++++++++++++++++
 tb/tb_rob_commit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_commit_pkg.sv
// Shared definitions for the reorder buffer: sizing, the "no dependency"
// tag value, the entry kind encodings and a tag range helper.
package rob_commit_pkg;

  localparam int          DEPTH  = 32;
  localparam int          IDX_W  = 5;
  localparam logic [31:0] NO_TAG = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    KIND_REG    = 2'd0,
    KIND_STORE  = 2'd1,
    KIND_BRANCH = 2'd2,
    KIND_JALR   = 2'd3
  } rob_kind_e;

  // Tags are 32 bits wide on the buses; only 0..DEPTH-1 name real entries.
  // NO_TAG and any other out-of-range value never match anything.
  function automatic logic tag_in_range(input logic [31:0] tag);
    return tag < 32'(DEPTH);
  endfunction

endpackage

// File: rtl/rob_tag_lookup.sv
// Operand tag resolution for one issue-time query port.
// Ports:
//   qry_tag              tag to resolve
//   busy, done, value    per-entry ROB state
//   rs_wb_*, slb_wb_*    same-cycle writebacks, used as a bypass
//   qry_ready/qry_value  result; 0/0 for NO_TAG or a non-busy entry
module rob_tag_lookup
  import rob_commit_pkg::*;
(
  input  logic [31:0]            qry_tag,
  input  logic [DEPTH-1:0]       busy,
  input  logic [DEPTH-1:0]       done,
  input  logic [DEPTH-1:0][31:0] value,
  input  logic                   rs_wb_valid,
  input  logic [31:0]            rs_wb_tag,
  input  logic [31:0]            rs_wb_value,
  input  logic                   slb_wb_valid,
  input  logic [31:0]            slb_wb_tag,
  input  logic [31:0]            slb_wb_value,
  output logic                   qry_ready,
  output logic [31:0]            qry_value
);

  logic [IDX_W-1:0] idx;
  logic             live;

  assign idx  = qry_tag[IDX_W-1:0];
  assign live = tag_in_range(qry_tag) && busy[idx];

  // Bypass order mirrors the storage update: RS over SLB over stored value.
  always_comb begin
    qry_ready = 1'b0;
    qry_value = '0;
    if (live) begin
      if (rs_wb_valid && rs_wb_tag == qry_tag) begin
        qry_ready = 1'b1;
        qry_value = rs_wb_value;
      end else if (slb_wb_valid && slb_wb_tag == qry_tag) begin
        qry_ready = 1'b1;
        qry_value = slb_wb_value;
      end else if (done[idx]) begin
        qry_ready = 1'b1;
        qry_value = value[idx];
      end
    end
  end

endmodule

// File: rtl/rob_commit.sv
// Reorder buffer: in-order tag allocation at issue, out-of-order result
// capture from the RS and SLB, in-order retirement one entry per cycle,
// registered commit broadcast, and the pipeline flush on a JALR mispredict.
// Ports:
//   clk, rst (sync, active-high), rdy (global enable)
//   issue_*          allocation request; issue_tag/rob_full combinational
//   qry1_*, qry2_*   operand resolution at issue (combinational)
//   rs_wb_*          RS results, incl. JALR computed target
//   slb_wb_*         store/load buffer completions
//   rob_rs_*         registered commit broadcast to waiting RS entries
//   commit_*         register-file write of the retiring entry
//   store_commit     SLB may perform the head store
//   clear/clear_pc   flush pulse and redirect PC
module rob_commit
  import rob_commit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        issue_valid,
  input  logic [1:0]  issue_kind,
  input  logic [4:0]  issue_rd,
  input  logic [31:0] issue_pred_pc,
  output logic [31:0] issue_tag,
  output logic        rob_full,
  input  logic [31:0] qry1_tag,
  input  logic [31:0] qry2_tag,
  output logic        qry1_ready,
  output logic        qry2_ready,
  output logic [31:0] qry1_value,
  output logic [31:0] qry2_value,
  input  logic        rs_wb_valid,
  input  logic [31:0] rs_wb_tag,
  input  logic [31:0] rs_wb_value,
  input  logic        rs_wb_topc_valid,
  input  logic [31:0] rs_wb_topc,
  input  logic        slb_wb_valid,
  input  logic [31:0] slb_wb_tag,
  input  logic [31:0] slb_wb_value,
  output logic        rob_rs_valid,
  output logic [31:0] rob_rs_tag,
  output logic [31:0] rob_rs_value,
  output logic        commit_rd_valid,
  output logic [4:0]  commit_rd,
  output logic [31:0] commit_tag,
  output logic        store_commit,
  output logic        clear,
  output logic [31:0] clear_pc
);

  localparam logic [IDX_W:0]   CNT_FULL = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH-1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic [DEPTH-1:0]       busy, done, topc_v;
  logic [DEPTH-1:0][31:0] value, pred_pc, topc;
  rob_kind_e              kind [DEPTH];
  logic [4:0]             rd   [DEPTH];

  logic [IDX_W-1:0] head, tail;
  logic [IDX_W:0]   count;

  logic             alloc, commit, mispredict, rs_hit, slb_hit, head_writes_rd;
  logic [IDX_W-1:0] rs_idx, slb_idx;
  logic [31:0]      head_tag;

  assign rob_full  = (count == CNT_FULL);
  assign issue_tag = {{(32-IDX_W){1'b0}}, tail};
  assign head_tag  = {{(32-IDX_W){1'b0}}, head};

  // Full is judged on the registered count, so a same-cycle retire does
  // not open a slot for the issue arriving in that cycle.
  assign alloc  = issue_valid && !rob_full;
  assign commit = busy[head] && done[head];
  assign mispredict = commit && kind[head] == KIND_JALR && topc_v[head] &&
                      topc[head] != pred_pc[head];
  assign head_writes_rd = (kind[head] == KIND_REG || kind[head] == KIND_JALR) &&
                          rd[head] != 5'd0;

  assign rs_idx  = rs_wb_tag[IDX_W-1:0];
  assign slb_idx = slb_wb_tag[IDX_W-1:0];
  assign rs_hit  = rs_wb_valid  && tag_in_range(rs_wb_tag)  && busy[rs_idx];
  assign slb_hit = slb_wb_valid && tag_in_range(slb_wb_tag) && busy[slb_idx];

  rob_tag_lookup u_qry1 (
    .qry_tag(qry1_tag), .busy(busy), .done(done), .value(value),
    .rs_wb_valid(rs_wb_valid), .rs_wb_tag(rs_wb_tag), .rs_wb_value(rs_wb_value),
    .slb_wb_valid(slb_wb_valid), .slb_wb_tag(slb_wb_tag), .slb_wb_value(slb_wb_value),
    .qry_ready(qry1_ready), .qry_value(qry1_value)
  );

  rob_tag_lookup u_qry2 (
    .qry_tag(qry2_tag), .busy(busy), .done(done), .value(value),
    .rs_wb_valid(rs_wb_valid), .rs_wb_tag(rs_wb_tag), .rs_wb_value(rs_wb_value),
    .slb_wb_valid(slb_wb_valid), .slb_wb_tag(slb_wb_tag), .slb_wb_value(slb_wb_value),
    .qry_ready(qry2_ready), .qry_value(qry2_value)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      busy            <= '0;
      done            <= '0;
      topc_v          <= '0;
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      rob_rs_valid    <= 1'b0;
      rob_rs_tag      <= NO_TAG;
      rob_rs_value    <= '0;
      commit_rd_valid <= 1'b0;
      commit_rd       <= '0;
      commit_tag      <= '0;
      store_commit    <= 1'b0;
      clear           <= 1'b0;
      clear_pc        <= '0;
    end else if (!rdy) begin
      // Stalled: state frozen, payloads hold, pulses suppressed.
      rob_rs_valid    <= 1'b0;
      commit_rd_valid <= 1'b0;
      store_commit    <= 1'b0;
      clear           <= 1'b0;
    end else begin
      rob_rs_valid    <= commit;
      commit_rd_valid <= commit && head_writes_rd;
      store_commit    <= commit && kind[head] == KIND_STORE;
      clear           <= mispredict;
      if (commit) begin
        rob_rs_tag   <= head_tag;
        rob_rs_value <= value[head];
        commit_rd    <= rd[head];
        commit_tag   <= head_tag;
      end
      if (mispredict) clear_pc <= topc[head];

      // SLB first so an RS result to the same tag overrides it.
      if (slb_hit) begin
        done[slb_idx]  <= 1'b1;
        value[slb_idx] <= slb_wb_value;
      end
      if (rs_hit) begin
        done[rs_idx]   <= 1'b1;
        value[rs_idx]  <= rs_wb_value;
        topc[rs_idx]   <= rs_wb_topc;
        topc_v[rs_idx] <= rs_wb_topc_valid;
      end

      if (alloc) begin
        busy[tail]    <= 1'b1;
        done[tail]    <= 1'b0;
        topc_v[tail]  <= 1'b0;
        kind[tail]    <= rob_kind_e'(issue_kind);
        rd[tail]      <= issue_rd;
        pred_pc[tail] <= issue_pred_pc;
        tail          <= (tail == IDX_LAST) ? '0 : tail + IDX_ONE;
      end
      if (commit) begin
        busy[head] <= 1'b0;
        head       <= (head == IDX_LAST) ? '0 : head + IDX_ONE;
      end

      case ({alloc, commit})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase

      // Flush overrides every update above made in this cycle.
      if (mispredict) begin
        busy  <= '0;
        done  <= '0;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
module tb_rob_commit;
  localparam logic [31:0] NO_TAG = 32'hFFFF_FFFF;

  logic        clk = 1'b0, rst, rdy;
  logic        issue_valid;
  logic [1:0]  issue_kind;
  logic [4:0]  issue_rd;
  logic [31:0] issue_pred_pc, issue_tag;
  logic        rob_full;
  logic [31:0] qry1_tag, qry2_tag, qry1_value, qry2_value;
  logic        qry1_ready, qry2_ready;
  logic        rs_wb_valid, rs_wb_topc_valid, slb_wb_valid;
  logic [31:0] rs_wb_tag, rs_wb_value, rs_wb_topc, slb_wb_tag, slb_wb_value;
  logic        rob_rs_valid, commit_rd_valid, store_commit, clear;
  logic [31:0] rob_rs_tag, rob_rs_value, commit_tag, clear_pc;
  logic [4:0]  commit_rd;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rob_commit dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_kind(issue_kind), .issue_rd(issue_rd),
    .issue_pred_pc(issue_pred_pc), .issue_tag(issue_tag), .rob_full(rob_full),
    .qry1_tag(qry1_tag), .qry2_tag(qry2_tag),
    .qry1_ready(qry1_ready), .qry2_ready(qry2_ready),
    .qry1_value(qry1_value), .qry2_value(qry2_value),
    .rs_wb_valid(rs_wb_valid), .rs_wb_tag(rs_wb_tag), .rs_wb_value(rs_wb_value),
    .rs_wb_topc_valid(rs_wb_topc_valid), .rs_wb_topc(rs_wb_topc),
    .slb_wb_valid(slb_wb_valid), .slb_wb_tag(slb_wb_tag), .slb_wb_value(slb_wb_value),
    .rob_rs_valid(rob_rs_valid), .rob_rs_tag(rob_rs_tag), .rob_rs_value(rob_rs_value),
    .commit_rd_valid(commit_rd_valid), .commit_rd(commit_rd), .commit_tag(commit_tag),
    .store_commit(store_commit), .clear(clear), .clear_pc(clear_pc)
  );

  // Inputs change 1 time unit after a rising edge, outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rdy = 1'b1; issue_valid = 1'b0; issue_kind = 2'd0; issue_rd = 5'd0; issue_pred_pc = '0;
    qry1_tag = NO_TAG; qry2_tag = NO_TAG;
    rs_wb_valid = 1'b0; rs_wb_tag = '0; rs_wb_value = '0; rs_wb_topc_valid = 1'b0; rs_wb_topc = '0;
    slb_wb_valid = 1'b0; slb_wb_tag = '0; slb_wb_value = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic issue(input logic [1:0] k, input logic [4:0] r, input logic [31:0] pc);
    issue_valid = 1'b1; issue_kind = k; issue_rd = r; issue_pred_pc = pc;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    issue(2'd0, 5'd3, 32'h0);
    step(); step();
    n_cmp++; if (rob_full !== 1'b0) begin n_err++; $display("FAIL reset_full got=%0b want=0", rob_full); end
    n_cmp++; if (issue_tag !== 32'd0) begin n_err++; $display("FAIL reset_tag got=%0d want=0", issue_tag); end
    n_cmp++; if (rob_rs_tag !== NO_TAG) begin n_err++; $display("FAIL reset_rs_tag got=%h want=%h", rob_rs_tag, NO_TAG); end
    n_cmp++; if ({rob_rs_valid, commit_rd_valid, store_commit, clear} !== 4'b0) begin
      n_err++; $display("FAIL reset_pulses got=%b want=0000", {rob_rs_valid, commit_rd_valid, store_commit, clear}); end
    n_cmp++; if (clear_pc !== 32'd0 || rob_rs_value !== 32'd0) begin
      n_err++; $display("FAIL reset_data got=%h/%h want=0/0", clear_pc, rob_rs_value); end
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_inorder_commit();
    do_reset();
    issue(2'd0, 5'd5, 32'h0); #1;
    n_cmp++; if (issue_tag !== 32'd0) begin n_err++; $display("FAIL io_tag0 got=%0d want=0", issue_tag); end
    step(); issue(2'd0, 5'd6, 32'h0); #1;
    n_cmp++; if (issue_tag !== 32'd1) begin n_err++; $display("FAIL io_tag1 got=%0d want=1", issue_tag); end
    step(); issue(2'd0, 5'd7, 32'h0); #1;
    n_cmp++; if (issue_tag !== 32'd2) begin n_err++; $display("FAIL io_tag2 got=%0d want=2", issue_tag); end
    step(); issue_valid = 1'b0;
    rs_wb_valid = 1'b1; rs_wb_tag = 32'd1; rs_wb_value = 32'h11;
    slb_wb_valid = 1'b1; slb_wb_tag = 32'd0; slb_wb_value = 32'h22;
    step(); rs_wb_valid = 1'b0; slb_wb_valid = 1'b0;
    n_cmp++; if (rob_rs_valid !== 1'b0) begin n_err++; $display("FAIL io_early got=%0b want=0", rob_rs_valid); end
    step();
    n_cmp++; if (rob_rs_valid !== 1'b1 || rob_rs_tag !== 32'd0 || rob_rs_value !== 32'h22) begin
      n_err++; $display("FAIL io_commit0 got=%0b/%0d/%h want=1/0/22", rob_rs_valid, rob_rs_tag, rob_rs_value); end
    n_cmp++; if (commit_rd_valid !== 1'b1 || commit_rd !== 5'd5 || commit_tag !== 32'd0) begin
      n_err++; $display("FAIL io_rd0 got=%0b/%0d/%0d want=1/5/0", commit_rd_valid, commit_rd, commit_tag); end
    step();
    n_cmp++; if (rob_rs_valid !== 1'b1 || rob_rs_tag !== 32'd1 || rob_rs_value !== 32'h11 || commit_rd !== 5'd6) begin
      n_err++; $display("FAIL io_commit1 got=%0b/%0d/%h/%0d want=1/1/11/6", rob_rs_valid, rob_rs_tag, rob_rs_value, commit_rd); end
    step();
    n_cmp++; if (rob_rs_valid !== 1'b0 || commit_rd_valid !== 1'b0) begin
      n_err++; $display("FAIL io_hold2 got=%0b/%0b want=0/0", rob_rs_valid, commit_rd_valid); end
    rs_wb_valid = 1'b1; rs_wb_tag = 32'd2; rs_wb_value = 32'h33;
    step(); rs_wb_valid = 1'b0;
    step();
    n_cmp++; if (rob_rs_valid !== 1'b1 || rob_rs_tag !== 32'd2 || rob_rs_value !== 32'h33 || commit_rd !== 5'd7) begin
      n_err++; $display("FAIL io_commit2 got=%0b/%0d/%h/%0d want=1/2/33/7", rob_rs_valid, rob_rs_tag, rob_rs_value, commit_rd); end
    idle_inputs();
  endtask

  task automatic test_full_wrap();
    do_reset();
    issue(2'd0, 5'd1, 32'h0);
    for (int i = 0; i < 32; i++) step();
    n_cmp++; if (rob_full !== 1'b1) begin n_err++; $display("FAIL fw_full got=%0b want=1", rob_full); end
    n_cmp++; if (issue_tag !== 32'd0) begin n_err++; $display("FAIL fw_tailwrap got=%0d want=0", issue_tag); end
    // issue_valid stays high: this edge is the dropped 33rd issue.
    rs_wb_valid = 1'b1; rs_wb_tag = 32'd0; rs_wb_value = 32'hA0;
    slb_wb_valid = 1'b1; slb_wb_tag = 32'd1; slb_wb_value = 32'hA1;
    step(); rs_wb_valid = 1'b0; slb_wb_valid = 1'b0;
    n_cmp++; if (rob_full !== 1'b1 || issue_tag !== 32'd0) begin
      n_err++; $display("FAIL fw_drop33 got=%0b/%0d want=1/0", rob_full, issue_tag); end
    step(); // commit tag0, issue still blocked by full
    n_cmp++; if (rob_rs_valid !== 1'b1 || rob_rs_tag !== 32'd0 || rob_rs_value !== 32'hA0) begin
      n_err++; $display("FAIL fw_commit0 got=%0b/%0d/%h want=1/0/a0", rob_rs_valid, rob_rs_tag, rob_rs_value); end
    n_cmp++; if (rob_full !== 1'b0 || issue_tag !== 32'd0) begin
      n_err++; $display("FAIL fw_blocked got=%0b/%0d want=0/0", rob_full, issue_tag); end
    step(); // commit tag1 and allocate tag0 together
    n_cmp++; if (rob_rs_tag !== 32'd1 || rob_rs_value !== 32'hA1 || rob_full !== 1'b0 || issue_tag !== 32'd1) begin
      n_err++; $display("FAIL fw_samecyc got=%0d/%h/%0b/%0d want=1/a1/0/1", rob_rs_tag, rob_rs_value, rob_full, issue_tag); end
    step(); // allocate only
    n_cmp++; if (rob_full !== 1'b1 || issue_tag !== 32'd2) begin
      n_err++; $display("FAIL fw_refill got=%0b/%0d want=1/2", rob_full, issue_tag); end
    idle_inputs();
  endtask

  task automatic test_bypass();
    do_reset();
    issue(2'd0, 5'd2, 32'h0);
    for (int i = 0; i < 5; i++) step();
    issue_valid = 1'b0;
    qry1_tag = 32'd4; qry2_tag = 32'd3;
    rs_wb_valid = 1'b1; rs_wb_tag = 32'd4; rs_wb_value = 32'hABCD;
    slb_wb_valid = 1'b1; slb_wb_tag = 32'd4; slb_wb_value = 32'h5555;
    #1;
    n_cmp++; if (qry1_ready !== 1'b1 || qry1_value !== 32'hABCD) begin
      n_err++; $display("FAIL bp_rs got=%0b/%h want=1/abcd", qry1_ready, qry1_value); end
    n_cmp++; if (qry2_ready !== 1'b0 || qry2_value !== 32'd0) begin
      n_err++; $display("FAIL bp_pending got=%0b/%h want=0/0", qry2_ready, qry2_value); end
    step(); rs_wb_valid = 1'b0; slb_wb_valid = 1'b0;
    qry2_tag = NO_TAG; #1;
    n_cmp++; if (qry1_ready !== 1'b1 || qry1_value !== 32'hABCD) begin
      n_err++; $display("FAIL bp_stored_rswin got=%0b/%h want=1/abcd", qry1_ready, qry1_value); end
    n_cmp++; if (qry2_ready !== 1'b0 || qry2_value !== 32'd0) begin
      n_err++; $display("FAIL bp_notag got=%0b/%h want=0/0", qry2_ready, qry2_value); end
    qry2_tag = 32'd10; slb_wb_valid = 1'b1; slb_wb_tag = 32'd10; slb_wb_value = 32'h77; #1;
    n_cmp++; if (qry2_ready !== 1'b0 || qry2_value !== 32'd0) begin
      n_err++; $display("FAIL bp_notbusy got=%0b/%h want=0/0", qry2_ready, qry2_value); end
    idle_inputs();
  endtask

  task automatic test_jalr();
    do_reset();
    issue(2'd3, 5'd1, 32'h104);
    step();
    issue(2'd0, 5'd4, 32'h0); // tag1, lost in the flush
    rs_wb_valid = 1'b1; rs_wb_tag = 32'd0; rs_wb_value = 32'h104;
    rs_wb_topc_valid = 1'b1; rs_wb_topc = 32'h200;
    step(); idle_inputs();
    step();
    n_cmp++; if (commit_rd_valid !== 1'b1 || commit_rd !== 5'd1 || rob_rs_value !== 32'h104) begin
      n_err++; $display("FAIL jr_rdwrite got=%0b/%0d/%h want=1/1/104", commit_rd_valid, commit_rd, rob_rs_value); end
    n_cmp++; if (clear !== 1'b1 || clear_pc !== 32'h200) begin
      n_err++; $display("FAIL jr_clear got=%0b/%h want=1/200", clear, clear_pc); end
    n_cmp++; if (rob_full !== 1'b0 || issue_tag !== 32'd0) begin
      n_err++; $display("FAIL jr_flush got=%0b/%0d want=0/0", rob_full, issue_tag); end
    step();
    n_cmp++; if (clear !== 1'b0 || rob_rs_valid !== 1'b0 || issue_tag !== 32'd0) begin
      n_err++; $display("FAIL jr_after got=%0b/%0b/%0d want=0/0/0", clear, rob_rs_valid, issue_tag); end
    // Correctly predicted JALR: rd write, no flush.
    issue(2'd3, 5'd2, 32'h300);
    step(); idle_inputs();
    rs_wb_valid = 1'b1; rs_wb_tag = 32'd0; rs_wb_value = 32'h3;
    rs_wb_topc_valid = 1'b1; rs_wb_topc = 32'h300;
    step(); idle_inputs();
    step();
    n_cmp++; if (clear !== 1'b0 || commit_rd_valid !== 1'b1 || commit_rd !== 5'd2) begin
      n_err++; $display("FAIL jr_goodpred got=%0b/%0b/%0d want=0/1/2", clear, commit_rd_valid, commit_rd); end
  endtask

  task automatic test_store_rd0();
    do_reset();
    issue(2'd1, 5'd3, 32'h0); step();
    issue(2'd0, 5'd0, 32'h0); step();
    issue_valid = 1'b0;
    slb_wb_valid = 1'b1; slb_wb_tag = 32'd0; slb_wb_value = 32'h0;
    rs_wb_valid = 1'b1; rs_wb_tag = 32'd1; rs_wb_value = 32'h77;
    step(); idle_inputs();
    step();
    n_cmp++; if (store_commit !== 1'b1 || commit_rd_valid !== 1'b0 || rob_rs_valid !== 1'b1) begin
      n_err++; $display("FAIL st_commit got=%0b/%0b/%0b want=1/0/1", store_commit, commit_rd_valid, rob_rs_valid); end
    step();
    n_cmp++; if (store_commit !== 1'b0 || commit_rd_valid !== 1'b0 || rob_rs_valid !== 1'b1 || rob_rs_value !== 32'h77) begin
      n_err++; $display("FAIL rd0_commit got=%0b/%0b/%0b/%h want=0/0/1/77", store_commit, commit_rd_valid, rob_rs_valid, rob_rs_value); end
  endtask

  task automatic test_rdy_hold();
    do_reset();
    issue(2'd0, 5'd9, 32'h0); step();
    issue_valid = 1'b0;
    rs_wb_valid = 1'b1; rs_wb_tag = 32'd0; rs_wb_value = 32'h99;
    step(); rs_wb_valid = 1'b0;
    rdy = 1'b0;
    issue(2'd0, 5'd8, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (rob_rs_valid !== 1'b0 || commit_rd_valid !== 1'b0 || issue_tag !== 32'd1) begin
        n_err++; $display("FAIL rdy_stall%0d got=%0b/%0b/%0d want=0/0/1", i, rob_rs_valid, commit_rd_valid, issue_tag); end
    end
    rdy = 1'b1; issue_valid = 1'b0;
    step();
    n_cmp++; if (rob_rs_valid !== 1'b1 || rob_rs_tag !== 32'd0 || rob_rs_value !== 32'h99 || commit_rd !== 5'd9) begin
      n_err++; $display("FAIL rdy_resume got=%0b/%0d/%h/%0d want=1/0/99/9", rob_rs_valid, rob_rs_tag, rob_rs_value, commit_rd); end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    #1;
    test_reset();
    test_inorder_commit();
    test_full_wrap();
    test_bypass();
    test_jalr();
    test_store_rd0();
    test_rdy_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
